qpl_trans_arb: RTL and testbench

QPL_TRANS_ARB -- requirements
Module: qpl_trans_arb

---
 rtl/qpl_pkg.sv | 16 +
 rtl/qpl_rr_arbiter.sv | 42 ++++
 rtl/qpl_trans_arb.sv | 172 +++++++++++++++++
 tb/tb_qpl_trans_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpl_pkg.sv
// rtl/qpl_pkg.sv - shared types and helpers for the translator arbiter
package qpl_pkg;

  // Arbiter control states: normal arbitration, wait for in-flight work, config lock
  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOCK  = 2'd2
  } qpl_state_e;

  // Translator pipeline latency in cycles for a given output-register setting
  function automatic int qpl_tr_lat(input int oreg_en);
    return (oreg_en != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/qpl_rr_arbiter.sv
// rtl/qpl_rr_arbiter.sv - round-robin one-hot grant starting after the last winner
module qpl_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_gnt_any
);

  int w_best;
  int w_best_dist;
  int w_dist;

  // Pick the requester closest after i_last in circular order (distance 0 = last+1)
  always_comb begin
    w_best      = 0;
    w_best_dist = NUM_REQ;
    w_dist      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
      if (i_req[j] && (w_dist < w_best_dist)) begin
        w_best      = j;
        w_best_dist = w_dist;
      end
    end
  end

  assign o_gnt_any = |i_req;
  assign o_gnt_id  = ID_W'(w_best);

  // Expand the winning index to a one-hot grant, empty when nobody requests
  always_comb begin
    o_gnt = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_gnt[j] = o_gnt_any && (w_best == j);
    end
  end

endmodule

// File: rtl/qpl_trans_arb.sv
// rtl/qpl_trans_arb.sv - shares one address translator among several requesters
module qpl_trans_arb
  import qpl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BLOCK_D = 128,
  parameter int WORD_W  = 8,
  parameter int OREG_EN = 1,
  localparam int BLOCK_W = $clog2(BLOCK_D),
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ-1:0]               i_req_we,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]   i_req_word,
  input  logic [NUM_REQ-1:0][BLOCK_W-1:0]  i_req_line,
  output logic                             o_tr_ignore,
  output logic                             o_tr_we,
  output logic [WORD_W-1:0]                o_tr_word,
  output logic [BLOCK_W-1:0]               o_tr_line,
  input  logic                             i_tr_we,
  input  logic [WORD_W-1:0]                i_tr_word,
  input  logic [BLOCK_W-1:0]               i_tr_line,
  output logic                             o_rsp_valid,
  output logic [ID_W-1:0]                  o_rsp_id,
  output logic                             o_rsp_we,
  output logic [WORD_W-1:0]                o_rsp_word,
  output logic [BLOCK_W-1:0]               o_rsp_line,
  input  logic                             i_scb_upd_req,
  output logic                             o_scb_upd_gnt
);

  localparam int TR_LAT = qpl_tr_lat(OREG_EN);

  qpl_state_e               r_state;
  qpl_state_e               w_next;
  logic [ID_W-1:0]          r_last;
  logic                     r_gnt;

  logic                     w_grant_en;
  logic [NUM_REQ-1:0]       w_req;
  logic [NUM_REQ-1:0]       w_gnt;
  logic [ID_W-1:0]          w_gnt_id;
  logic                     w_xfer;
  logic                     w_empty;
  logic                     w_rsp_valid;
  logic [ID_W-1:0]          w_rsp_id;
  logic                     w_tr_we;
  logic [WORD_W-1:0]        w_tr_word;
  logic [BLOCK_W-1:0]       w_tr_line;

  // Grants only in ARB, never while reset is asserted, and a config request blocks them
  assign w_grant_en = i_rst_n && (r_state == ST_ARB) && !i_scb_upd_req;
  assign w_req      = i_req_valid & {NUM_REQ{w_grant_en}};

  qpl_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req     (w_req),
    .i_last    (r_last),
    .o_gnt     (w_gnt),
    .o_gnt_id  (w_gnt_id),
    .o_gnt_any (w_xfer)
  );

  assign o_req_ready = w_gnt;

  // Route the granted requester's payload to the translator, zero when idle
  always_comb begin
    w_tr_we   = 1'b0;
    w_tr_word = '0;
    w_tr_line = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_tr_we   = i_req_we[i];
        w_tr_word = i_req_word[i];
        w_tr_line = i_req_line[i];
      end
    end
  end

  assign o_tr_ignore = ~w_xfer;
  assign o_tr_we     = w_tr_we;
  assign o_tr_word   = w_tr_word;
  assign o_tr_line   = w_tr_line;

  // Next-state: config request drains outstanding translations before granting the lock
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ARB: begin
        if (i_scb_upd_req) begin
          w_next = (TR_LAT == 0) ? ST_LOCK : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!i_scb_upd_req) begin
          w_next = ST_ARB;
        end else if (w_empty) begin
          w_next = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (!i_scb_upd_req) begin
          w_next = ST_ARB;
        end
      end
      default: w_next = ST_ARB;
    endcase
  end

  // State register; the lock grant is registered so it is high exactly while in LOCK
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_ARB;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt   <= (w_next == ST_LOCK);
    end
  end

  // Round-robin pointer moves only when a transfer actually happens
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (w_xfer) begin
      r_last <= w_gnt_id;
    end
  end

  generate
    if (TR_LAT == 0) begin : g_no_lat
      assign w_empty     = 1'b1;
      assign w_rsp_valid = w_xfer;
      assign w_rsp_id    = w_gnt_id;
    end else begin : g_lat
      logic [TR_LAT-1:0]           r_fv;
      logic [TR_LAT-1:0][ID_W-1:0] r_fid;

      // In-flight tracker mirrors the translator pipeline so responses carry their owner
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_fv  <= '0;
          r_fid <= '0;
        end else begin
          r_fv[0]  <= w_xfer;
          r_fid[0] <= w_gnt_id;
          for (int k = 1; k < TR_LAT; k++) begin
            r_fv[k]  <= r_fv[k-1];
            r_fid[k] <= r_fid[k-1];
          end
        end
      end

      assign w_empty     = ~|r_fv;
      assign w_rsp_valid = i_rst_n & r_fv[TR_LAT-1];
      assign w_rsp_id    = r_fid[TR_LAT-1];
    end
  endgenerate

  assign o_rsp_valid   = w_rsp_valid;
  assign o_rsp_id      = w_rsp_valid ? w_rsp_id : '0;
  assign o_rsp_we      = w_rsp_valid & i_tr_we;
  assign o_rsp_word    = w_rsp_valid ? i_tr_word : '0;
  assign o_rsp_line    = w_rsp_valid ? i_tr_line : '0;
  assign o_scb_upd_gnt = r_gnt;

endmodule

// File: tb/tb_qpl_trans_arb.sv
// tb/tb_qpl_trans_arb.sv - scoreboard bench for the translator arbiter
module tb_qpl_trans_arb;

  localparam int N  = 4;
  localparam int BD = 128;
  localparam int BW = 7;
  localparam int WW = 8;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic          we;
    logic [WW-1:0] word;
    logic [BW-1:0] line;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [N-1:0]           req_valid, req_ready, req_we;
  logic [N-1:0][WW-1:0]   req_word;
  logic [N-1:0][BW-1:0]   req_line;
  logic                   tr_ignore, tr_we_o, tr_we_i;
  logic [WW-1:0]          tr_word_o, tr_word_i;
  logic [BW-1:0]          tr_line_o, tr_line_i;
  logic                   rsp_valid, rsp_we;
  logic [IW-1:0]          rsp_id;
  logic [WW-1:0]          rsp_word;
  logic [BW-1:0]          rsp_line;
  logic                   scb_req, scb_gnt;

  logic [0:0]             v0, rdy0, we0;
  logic [0:0][WW-1:0]     word0;
  logic [0:0][BW-1:0]     line0;
  logic                   ign0, trwe0_o, trwe0_i;
  logic [WW-1:0]          trword0_o, trword0_i;
  logic [BW-1:0]          trline0_o, trline0_i;
  logic                   rv0, rwe0;
  logic [0:0]             rid0;
  logic [WW-1:0]          rword0;
  logic [BW-1:0]          rline0;
  logic                   scb0, gnt0;

  int   n_checks = 0;
  int   n_pass   = 0;
  rsp_t sbq[$];
  rsp_t mon_e;
  logic [N-1:0] p;
  int   last_m;
  bit   push_en;

  function automatic logic [BW-1:0] tr_map(input logic [BW-1:0] l);
    return BW'((int'(l) * 3 + 7) % BD);
  endfunction

  qpl_trans_arb #(.NUM_REQ(N), .BLOCK_D(BD), .WORD_W(WW), .OREG_EN(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_word(req_word), .i_req_line(req_line),
    .o_tr_ignore(tr_ignore), .o_tr_we(tr_we_o), .o_tr_word(tr_word_o), .o_tr_line(tr_line_o),
    .i_tr_we(tr_we_i), .i_tr_word(tr_word_i), .i_tr_line(tr_line_i),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_we(rsp_we),
    .o_rsp_word(rsp_word), .o_rsp_line(rsp_line),
    .i_scb_upd_req(scb_req), .o_scb_upd_gnt(scb_gnt)
  );

  qpl_trans_arb #(.NUM_REQ(1), .BLOCK_D(BD), .WORD_W(WW), .OREG_EN(0)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(v0), .o_req_ready(rdy0), .i_req_we(we0),
    .i_req_word(word0), .i_req_line(line0),
    .o_tr_ignore(ign0), .o_tr_we(trwe0_o), .o_tr_word(trword0_o), .o_tr_line(trline0_o),
    .i_tr_we(trwe0_i), .i_tr_word(trword0_i), .i_tr_line(trline0_i),
    .o_rsp_valid(rv0), .o_rsp_id(rid0), .o_rsp_we(rwe0),
    .o_rsp_word(rword0), .o_rsp_line(rline0),
    .i_scb_upd_req(scb0), .o_scb_upd_gnt(gnt0)
  );

  // Translator stand-ins: registered for the OREG_EN=1 instance, combinational otherwise
  always @(posedge clk) begin
    tr_we_i   <= tr_we_o;
    tr_word_i <= tr_word_o ^ 8'h5A;
    tr_line_i <= tr_map(tr_line_o);
  end
  assign trwe0_i   = trwe0_o;
  assign trword0_i = trword0_o ^ 8'h5A;
  assign trline0_i = tr_map(trline0_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Response monitor: a response is due exactly when one was queued the previous cycle
  always @(negedge clk) begin
    chk("rsp_valid", 32'(rsp_valid), (sbq.size() != 0) ? 32'd1 : 32'd0);
    if (rsp_valid && sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
      chk("rsp_we", 32'(rsp_we), 32'(mon_e.we));
      chk("rsp_word", 32'(rsp_word), 32'(mon_e.word));
      chk("rsp_line", 32'(rsp_line), 32'(mon_e.line));
    end else if (!rsp_valid) begin
      chk("rsp_idle_zero", 32'({rsp_id, rsp_we, rsp_word, rsp_line}), 32'd0);
    end
  end

  // One arbitration cycle: new requests arrive, the model picks the winner, scoreboard is fed
  task automatic step(input bit blk, input int pct, input logic [N-1:0] frc,
                      input logic scb, input logic exp_gnt);
    int            g;
    logic [IW-1:0] ci;
    logic [N-1:0]  exp_rdy;
    rsp_t          e;
    @(posedge clk); #1;
    scb_req = scb;
    for (int i = 0; i < N; i++) begin
      if (!p[i] && (frc[i] || (int'($urandom_range(99)) < pct))) begin
        p[i]        = 1'b1;
        req_we[i]   = 1'($urandom);
        req_word[i] = WW'($urandom);
        req_line[i] = BW'($urandom);
      end
    end
    req_valid = p;
    @(negedge clk); #1;
    g = -1;
    if (!blk) begin
      for (int k = 1; k <= N; k++) begin
        ci = IW'((last_m + k) % N);
        if (g < 0 && p[ci]) g = int'(ci);
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[IW'(g)] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("tr_ignore", 32'(tr_ignore), (g < 0) ? 32'd1 : 32'd0);
    chk("scb_upd_gnt", 32'(scb_gnt), 32'(exp_gnt));
    if (g >= 0) begin
      ci = IW'(g);
      chk("tr_line", 32'(tr_line_o), 32'(req_line[ci]));
      e.id   = ci;
      e.we   = req_we[ci];
      e.word = req_word[ci] ^ 8'h5A;
      e.line = tr_map(req_line[ci]);
      if (push_en) sbq.push_back(e);
      last_m = g;
      p[ci]  = 1'b0;
    end
  endtask

  task automatic reset_checks();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ignore", 32'(tr_ignore), 32'd1);
    chk("rst_tr_we", 32'(tr_we_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_scb_gnt", 32'(scb_gnt), 32'd0);
    chk("rst_d0_ready", 32'(rdy0), 32'd0);
  endtask

  // Single-requester, zero-latency instance: response in the transfer cycle
  task automatic d0_cycle(input logic v, input logic scb, input logic e_rsp, input logic e_gnt);
    @(posedge clk); #1;
    v0       = v;
    scb0     = scb;
    we0      = 1'($urandom);
    word0[0] = WW'($urandom);
    line0[0] = BW'($urandom);
    @(negedge clk); #1;
    chk("d0_ready", 32'(rdy0), 32'(e_rsp));
    chk("d0_rsp_valid", 32'(rv0), 32'(e_rsp));
    chk("d0_ignore", 32'(ign0), 32'(!e_rsp));
    chk("d0_scb_gnt", 32'(gnt0), 32'(e_gnt));
    if (e_rsp) begin
      chk("d0_rsp_id", 32'(rid0), 32'd0);
      chk("d0_rsp_we", 32'(rwe0), 32'(we0));
      chk("d0_rsp_word", 32'(rword0), 32'(word0[0] ^ 8'h5A));
      chk("d0_rsp_line", 32'(rline0), 32'(tr_map(line0[0])));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_we    = '0;
    req_word  = '0;
    req_line  = '0;
    scb_req   = 1'b0;
    v0        = 1'b1;
    we0       = '0;
    word0     = '0;
    line0     = '0;
    scb0      = 1'b0;
    p         = '0;
    last_m    = N - 1;
    push_en   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset_checks();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = '0;
    v0        = 1'b0;

    // All requesters busy: strict 0,1,2,3,0,... rotation
    repeat (8) step(0, 100, '1, 1'b0, 1'b0);
    // Random traffic
    repeat (300) step(0, 40, '0, 1'b0, 1'b0);
    repeat (N + 1) step(0, 0, '0, 1'b0, 1'b0);

    // Config lock right after a transfer; pending 1 and 3 resume at preserved pointer
    step(0, 0, 4'b0010, 1'b0, 1'b0);
    step(1, 0, 4'b1010, 1'b1, 1'b0);
    step(1, 0, '0, 1'b1, 1'b0);
    step(1, 0, '0, 1'b1, 1'b1);
    step(1, 0, '0, 1'b0, 1'b1);
    step(0, 0, '0, 1'b0, 1'b0);
    step(0, 0, '0, 1'b0, 1'b0);

    // Config request withdrawn during drain: no lock grant
    step(1, 0, '0, 1'b1, 1'b0);
    step(1, 0, '0, 1'b0, 1'b0);
    step(0, 0, 4'b0100, 1'b0, 1'b0);
    step(0, 0, '0, 1'b0, 1'b0);

    // Reset with a transfer in flight: its response must vanish, pointer restarts at 0
    push_en = 1'b0;
    step(0, 0, 4'b0100, 1'b0, 1'b0);
    push_en = 1'b1;
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '1;
    @(negedge clk); #1;
    reset_checks();
    @(posedge clk); #1;
    @(negedge clk); #1;
    reset_checks();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    p         = '0;
    req_valid = '0;
    last_m    = N - 1;
    step(0, 0, 4'b1001, 1'b0, 1'b0);
    step(0, 0, '0, 1'b0, 1'b0);
    step(0, 0, '0, 1'b0, 1'b0);

    // Zero-latency single-requester instance, including direct ARB->LOCK
    repeat (4) d0_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    d0_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    d0_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    d0_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    d0_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    d0_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk); #1;

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
